// File: rtl/mux_nto1_seq.sv
// Registered N-to-1 mux with manual channel select and round-robin auto-scan, valid/ready output.
// Optional MUX_NTO1_SEQ_MASK_EN adds ch_mask to restrict which channels take part in scan.
//
// state  | meaning
// IDLE   | no captures; entered when disabled with nothing pending
// MANUAL | channel set by sel/sel_load
// SCAN   | channel advances round-robin every DWELL samples
module mux_nto1_seq #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 3,
   localparam int SELW     = $clog2(CHANNELS),
   localparam int DWW      = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      enable,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   input  logic                      sel_load,
`ifdef MUX_NTO1_SEQ_MASK_EN
   input  logic [CHANNELS-1:0]       ch_mask,
`endif
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef enum logic [1:0] {S_IDLE, S_MANUAL, S_SCAN} state_t;

   localparam logic [SELW:0]  CH_LIM  = (SELW+1)'(CHANNELS);
   localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SELW-1:0]  r_ch;
   logic [DWW-1:0]   r_dwell;
   logic [CHANNELS-1:0] w_mask;
   logic             w_xfer;
   logic             w_load;
   logic             w_enter_scan;
   logic [WIDTH-1:0] w_chan [2**SELW];

`ifdef MUX_NTO1_SEQ_MASK_EN
   assign w_mask = ch_mask;
`else
   assign w_mask = '1;
`endif

   for (genvar k = 0; k < 2**SELW; k++) begin : g_chan
      if (k < CHANNELS) begin : g_used
         assign w_chan[k] = data_in[k*WIDTH +: WIDTH];
      end else begin : g_unused
         assign w_chan[k] = '0;
      end
   end

   function automatic logic [SELW-1:0] f_first(input logic [CHANNELS-1:0] m);
      logic [SELW-1:0] r;
      r = '0;
      for (int k = CHANNELS-1; k >= 0; k--)
         if (m[k]) r = SELW'(k);
      return r;
   endfunction

   // Smallest forward offset wins; with no other channel enabled the current one repeats.
   function automatic logic [SELW-1:0] f_next(input logic [SELW-1:0] cur,
                                              input logic [CHANNELS-1:0] m);
      logic [SELW-1:0] r;
      int idx;
      r = cur;
      for (int o = CHANNELS-1; o >= 1; o--) begin
         idx = (int'(cur) + o) % CHANNELS;
         if (m[idx]) r = SELW'(idx);
      end
      return r;
   endfunction

   always_comb begin
      w_xfer      = out_valid & out_ready;
      w_state_nxt = r_state;
      if (!enable && (!out_valid || w_xfer))
         w_state_nxt = S_IDLE;
      else if (enable)
         w_state_nxt = mode ? S_SCAN : S_MANUAL;
      w_load = enable && (!out_valid || w_xfer) &&
               ((r_state == S_MANUAL) || ((r_state == S_SCAN) && (|w_mask)));
      w_enter_scan = (w_state_nxt == S_SCAN) && (r_state != S_SCAN);
   end

   // Dwell counts samples launched in scan; each one leaves as exactly one accepted transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_dwell   <= '0;
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            out_data  <= w_chan[r_ch];
            out_ch    <= r_ch;
            out_valid <= 1'b1;
         end else if (w_xfer) begin
            out_valid <= 1'b0;
         end
         if (w_enter_scan) begin
            r_ch    <= f_first(w_mask);
            r_dwell <= '0;
         end else if ((r_state == S_MANUAL) && sel_load && ({1'b0, sel} < CH_LIM)) begin
            r_ch <= sel;
         end else if ((r_state == S_SCAN) && w_load) begin
            if (r_dwell == DW_LAST) begin
               r_dwell <= '0;
               r_ch    <= f_next(r_ch, w_mask);
            end else begin
               r_dwell <= r_dwell + DWW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Bench for mux_nto1_seq: directed manual/backpressure/scan/reset steps plus randomized phases
// checked against a transaction-level reference. Mask steps run when MUX_NTO1_SEQ_MASK_EN is defined.
module tb_mux_nto1_seq;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int DWELL    = 3;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic                      enable;
   logic                      mode;
   logic [1:0]                sel;
   logic                      sel_load;
   logic [CHANNELS-1:0]       ch_mask;
   logic [WIDTH-1:0]          out_data;
   logic [1:0]                out_ch;
   logic                      out_valid;
   logic                      out_ready;

   int n_chk = 0;
   int n_err = 0;
   int idx;
   int e_ch;
   bit found;
   bit xfer;
   logic [WIDTH-1:0] chd [CHANNELS];
   logic [1:0]       m_ch;
   logic [1:0]       m_och;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;

   mux_nto1_seq #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_in   (data_in),
      .enable    (enable),
      .mode      (mode),
      .sel       (sel),
      .sel_load  (sel_load),
`ifdef MUX_NTO1_SEQ_MASK_EN
      .ch_mask   (ch_mask),
`endif
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data();
      for (int k = 0; k < CHANNELS; k++) data_in[k*WIDTH +: WIDTH] = chd[k];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; mode = 1'b0; sel = '0; sel_load = 1'b0;
      out_ready = 1'b1; ch_mask = '1;
      for (int k = 0; k < CHANNELS; k++) chd[k] = '0;
      set_data();
      #12 reset_n = 1'b1;

      // reset / idle
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_valid", out_valid, 0);
         chk("idle_data", out_data, 0);
         chk("idle_ch", out_ch, 0);
      end

      // manual select
      chd[0] = 8'h11; chd[1] = 8'h22; chd[2] = 8'h33; chd[3] = 8'h44; set_data();
      enable = 1'b1; mode = 1'b0;
      tick(); chk("man_first_edge_valid", out_valid, 0);
      sel = 2'd2; sel_load = 1'b1;
      tick(); chk("man_old_ch", out_ch, 0); chk("man_old_data", out_data, 8'h11);
      chk("man_valid", out_valid, 1);
      sel_load = 1'b0;
      tick(); chk("man_ch2", out_ch, 2); chk("man_data2", out_data, 8'h33);
      tick(); chk("man_ch2_again", out_ch, 2); chk("man_data2_again", out_data, 8'h33);
      sel = 2'd3; sel_load = 1'b1;
      tick(); chk("man_load3_old", out_ch, 2);
      sel_load = 1'b0;
      tick(); chk("man_ch3", out_ch, 3); chk("man_data3", out_data, 8'h44);

      // backpressure
      sel = 2'd1; sel_load = 1'b1;
      tick(); sel_load = 1'b0;
      tick(); chk("bp_ch1", out_ch, 1); chk("bp_data22", out_data, 8'h22);
      out_ready = 1'b0; chd[1] = 8'h99; set_data();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_hold_data", out_data, 8'h22);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ch", out_ch, 1);
      end
      out_ready = 1'b1;
      tick(); chk("bp_release_data", out_data, 8'h99);

      // drain to idle, then scan with random backpressure
      enable = 1'b0;
      tick(); chk("drain_valid", out_valid, 0);
      tick(); chk("idle2_valid", out_valid, 0);
      for (int k = 0; k < CHANNELS; k++) chd[k] = WIDTH'($urandom);
      set_data();
      mode = 1'b1; enable = 1'b1;
      tick(); chk("scan_lat1_valid", out_valid, 0);
      tick(); chk("scan_lat2_valid", out_valid, 1);
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         e_ch = (idx / DWELL) % CHANNELS;
         chk("scan_ch", out_ch, e_ch);
         chk("scan_data", out_data, chd[e_ch]);
         chk("scan_valid", out_valid, 1);
         out_ready = (c < 13) ? 1'b1 : 1'($urandom_range(0, 1));
         xfer = out_ready;
         tick();
         if (xfer) idx++;
      end

      // reset mid-scan at channel 2
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         if ((idx / DWELL) % CHANNELS == 2) found = 1'b1;
         else begin tick(); idx++; end
      end
      chk("rst_find_ch2", found, 1);
      chk("rst_pre_ch", out_ch, 2);
      chk("rst_pre_valid", out_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_valid", out_valid, 0);
      chk("rst_async_data", out_data, 0);
      chk("rst_async_ch", out_ch, 0);
      #1 reset_n = 1'b1;
      tick(); chk("rst_restart_lat", out_valid, 0);
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         e_ch = (idx / DWELL) % CHANNELS;
         chk("rst_restart_valid", out_valid, 1);
         chk("rst_restart_ch", out_ch, e_ch);
         idx++;
      end

      // randomized manual mode against a sample-level model
      mode = 1'b0; enable = 1'b1; sel_load = 1'b0;
      #1 reset_n = 1'b0;
      #2 reset_n = 1'b1;
      tick(); chk("mr_lat_valid", out_valid, 0);
      m_ch = '0; m_och = '0; m_data = '0; m_valid = 1'b0;
      for (int c = 0; c < 80; c++) begin
         for (int k = 0; k < CHANNELS; k++) chd[k] = WIDTH'($urandom);
         set_data();
         out_ready = ($urandom_range(0, 3) != 0);
         sel_load  = ($urandom_range(0, 2) == 0);
         sel       = 2'($urandom_range(0, 3));
         xfer = m_valid && out_ready;
         if (!m_valid || xfer) begin
            m_data = chd[m_ch]; m_och = m_ch; m_valid = 1'b1;
         end
         if (sel_load) m_ch = sel;
         tick();
         chk("mr_valid", out_valid, m_valid);
         chk("mr_ch", out_ch, m_och);
         chk("mr_data", out_data, m_data);
      end
      sel_load = 1'b0;

`ifdef MUX_NTO1_SEQ_MASK_EN
      out_ready = 1'b1; ch_mask = 4'b1010; mode = 1'b1;
      tick();
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("mask_ch", out_ch, ((k / DWELL) % 2 == 1) ? 3 : 1);
      end
      ch_mask = '0; out_ready = 1'b0;
      tick(); chk("mask0_pending", out_valid, 1);
      out_ready = 1'b1;
      tick(); chk("mask0_drained", out_valid, 0);
      tick(); chk("mask0_stays", out_valid, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_nto1_seq.md
# mux_nto1_seq

Parametrised registered N-to-1 multiplexer: the successor to the gate-level 2-to-1 mux, generalised to CHANNELS inputs of WIDTH bits. It offers a manual select mode and an auto-scan mode that steps round-robin through the channels. The output is a single registered stage with a valid/ready handshake. It sits between a bank of sampled sources (switches, counters, sensor registers) and a single downstream consumer such as a display driver or UART formatter.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); SELW = $clog2(CHANNELS)
- DWELL, 3, accepted transfers per channel before scan advances (≥1)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- enable  in  1  1 = capture allowed; 0 = no new captures
- mode  in  1  0 = manual, 1 = scan
- sel  in  SELW  manual channel request
- sel_load  in  1  strobe; latch sel into the channel register (manual mode only)
- out_data  out  WIDTH  registered selected data
- out_ch  out  SELW  channel index of out_data
- out_valid  out  1  out_data/out_ch hold a sample
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- State machine: IDLE, MANUAL, SCAN.
  - Reset → IDLE.
  - IDLE → MANUAL (mode=0) or SCAN (mode=1) when enable=1.
  - Any state → IDLE when enable=0 and no sample is pending (out_valid=0 or transfer this cycle).
  - MANUAL ↔ SCAN follows mode directly.
- Channel register ch:
  - MANUAL: on sel_load=1, ch ← sel. A sel value ≥ CHANNELS is ignored and ch is unchanged.
  - Entering SCAN from any state: ch ← first enabled channel (0 without mask), dwell ← 0.
  - SCAN: on each accepted transfer, dwell increments. At dwell = DWELL-1, dwell ← 0 and ch ← next channel with wrap CHANNELS-1 → 0.
  - sel and sel_load are ignored in SCAN.
- Capture:
  - In MANUAL or SCAN with enable=1, the output stage loads when out_valid=0 or a transfer occurs this cycle.
  - On load: out_data ← data_in[ch], out_ch ← ch, out_valid ← 1.
  - Otherwise the stage holds. out_data, out_ch and out_valid are stable while out_valid=1 and out_ready=0.
- Capture uses ch as it stands before any same-cycle update of ch.
- Simultaneous sel_load and transfer: the new sample uses the old ch. The next sample uses the new ch.
- enable falling while a sample is pending: the sample is held until accepted, then out_valid ← 0.

## Timing
- Reset values: out_data=0, out_ch=0, out_valid=0, ch=0, dwell=0, state IDLE.
- Latency: enable rising with a valid mode → out_valid=1 on the 2nd rising edge (one edge for IDLE→mode, one for capture).
- Throughput: with out_ready held at 1, one sample per cycle.
- Manual select latency: sel_load at edge n updates ch at edge n. The first sample of the new channel appears at edge n+1.
- Scan: the channel changes every DWELL accepted transfers. With out_ready=1 the sequence is ch0×DWELL, ch1×DWELL, …, wrapping.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any pending sample is discarded.

## Configuration
- MUX_NTO1_SEQ_MASK_EN defined:
  - Adds input ch_mask [CHANNELS], where 1 = channel participates in scan.
  - SCAN advance skips masked channels, wrapping as needed.
  - Entering SCAN selects the lowest enabled channel.
  - If ch_mask = 0 in SCAN: no new captures, any pending sample is still drained, ch holds.
  - If the current channel becomes masked: it completes its current dwell, then advances.
  - MANUAL mode ignores the mask.
- Undefined: no ch_mask port. All channels are scanned 0…CHANNELS-1.

## Test plan
- Reset/idle: reset_n=0 then 1, enable=0 for 5 cycles → out_valid=0, out_data=0, out_ch=0 throughout.
- Manual select, CHANNELS=4, WIDTH=8, data_in={8'h44,8'h33,8'h22,8'h11}, mode=0, enable=1, sel=2 with sel_load pulse, out_ready=1 → out_ch=2 and out_data=8'h33 from the next sample onward. A sel_load with sel=3 then gives 8'h44.
- Backpressure: manual ch=1, out_ready=0 for 4 cycles while data_in channel 1 changes 8'h22→8'h99 → out_data holds 8'h22, out_valid=1. The cycle after out_ready=1 loads 8'h99.
- Scan wrap: mode=1, DWELL=3, out_ready=1 → out_ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. Dropping out_ready mid-dwell stalls both the sequence and the dwell count.
- Mid-operation reset: reset_n pulsed low while out_valid=1 in SCAN at ch=2 → all outputs 0 immediately. After release with enable=1, scan restarts at ch=0.
- Mask (MUX_NTO1_SEQ_MASK_EN): ch_mask=4'b1010, DWELL=1 → out_ch 1,3,1,3. ch_mask=0 → out_valid drops after the pending sample is accepted.
